iir_biquad_mc: RTL and testbench
================================

# iir_biquad_mc

Parametrised multi-channel direct-form-II biquad IIR filter. It is the successor to the single-channel 9-bit IIR core. It processes up to NCH time-interleaved channels through one shared datapath, with per-channel coefficient sets and per-channel filter state. It drops into the existing data_maker → filter → data_sink bench flow, with a channel tag added on the input and output streams.

## Interface
- WIDTH, 9: sample and coefficient width, two's complement.
- FRAC, WIDTH-2: coefficient fractional bits (Q2.FRAC, range [-2, 2)).
- NCH, 4: channel count, at least 1; CW = max(1, $clog2(NCH)).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- din  in  WIDTH  input sample.
- vin  in  1  input valid; a sample is accepted every cycle it is high.
- ch_in  in  CW  channel of din.
- clr  in  1  clear the state of channel clr_ch.
- clr_ch  in  CW  channel to clear.
- cfg_we  in  1  coefficient write strobe.
- cfg_ch  in  CW  channel whose coefficient is written.
- cfg_sel  in  3  coefficient select: 0=a1, 1=a2, 2=b0, 3=b1, 4=b2; 5–7 are ignored.
- cfg_data  in  WIDTH  coefficient value.
- dout  out  WIDTH  filtered sample.
- vout  out  1  output valid.
- ch_out  out  CW  channel of dout.

## Operation
- Per-channel state: w1[c] and w2[c], each WIDTH bits. Per-channel coefficients: a1, a2, b0, b1, b2.
- Stage 1, at the accepting edge: register din, ch_in and vin.
- Stage 2, combinational from the registers, then registered at the next edge:
  - acc_w = (x << FRAC) − a1·w1 − a2·w2, computed at 2·WIDTH+3 bits.
  - w = fit(acc_w >>> FRAC). The shift is arithmetic, so it floors.
  - acc_y = b0·w + b1·w1 + b2·w2.
  - y = fit(acc_y >>> FRAC).
- At that same edge: w2[c] ← w1[c], w1[c] ← w, dout ← y, ch_out ← c, vout ← 1.
- fit(): saturation or two's-complement wrap to WIDTH bits; see Configuration. y is computed from the fitted w.
- Coefficient write: on a cfg_we edge the selected register is updated. Samples accepted on a later edge use the new value. A sample whose stage-2 edge coincides with the write uses the old value.
- clr: zeroes w1[clr_ch] and w2[clr_ch] at the edge. When it hits the same channel the pipeline writes at that edge, clr wins. The output sample of that edge is still emitted normally.
- Out-of-range ch_in (≥ NCH) is dropped: no state update, vout stays 0. Out-of-range cfg_ch and clr_ch are ignored.

## Timing
- Reset values: dout=0, vout=0, ch_out=0, all state=0, all coefficients=0.
- Latency: vin sampled at edge t gives vout=1 during the cycle after edge t+1.
- Throughput: one sample per cycle, from any channel mix.
- Back-to-back samples on the same channel are hazard-free: state is written at t+1, before the next sample's computation reads it.
- vout is a one-cycle pulse per accepted sample; there is no backpressure.
- Reset mid-stream discards the in-flight sample. vout is 0 from assertion until the first accepted sample after release.

## Configuration
- IIR_SAT_EN defined: fit() saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1] for both w and y.
- IIR_SAT_EN undefined: fit() keeps the low WIDTH bits (wrap). No saturation logic is built.

## Structure
- Package iir_pkg holds:
  - cfg_sel codes: SEL_A1..SEL_B2.
  - Accumulator-width function: ACC_W = 2·WIDTH+3.
  - The sat/wrap helper function.
- Sub-module iir_coef_bank: per-channel coefficient register file with the cfg write port and a read port indexed by the stage-1 channel.
- The top level holds the state RAM, the pipeline registers and the arithmetic.

## Test plan
All scenarios use WIDTH=9, FRAC=7.
- Pass-through gain: ch0 with b0=64 (0.5), others 0. din=100 → dout=50, ch_out=0 one cycle after acceptance.
- Recursion: ch0 with b0=128, a1=−64 (0x1C0). Inputs 64, 0, 0, 0 back-to-back → dout 64, 32, 16, 8.
- Interleave: ch0 configured as in the recursion test, ch1 with b0=32. Alternate ch0/ch1 impulses of 64 then zeros.
  - ch0 → 64, 32, 16.
  - ch1 → 16, 0, 0.
  - No cross-talk between channels.
- Overflow: b0=255, din=255.
  - With IIR_SAT_EN → dout=255.
  - Without → dout=−4 (508 wrapped).
- Clear: after the first recursion output, assert clr with clr_ch=0 on the stage-2 edge of the second sample. The output is still 32, and the next zero input gives dout=0.
- Reset mid-stream: assert rst while vout is pending → vout=0 and dout=0 immediately. After release, the first new impulse of 64 yields 0, since all coefficients were reset to 0.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the multi-channel biquad IIR filter.
// Configuration macro: IIR_SAT_EN (saturating fit when defined, wrapping fit otherwise).
package iir_pkg;

  // Coefficient select codes carried on cfg_sel
  typedef enum logic [2:0] {
    SEL_A1 = 3'd0,
    SEL_A2 = 3'd1,
    SEL_B0 = 3'd2,
    SEL_B1 = 3'd3,
    SEL_B2 = 3'd4
  } sel_e;

  // Accumulator width: full product width plus headroom for three-term sums
  function automatic int unsigned acc_width(input int unsigned w);
    return 2 * w + 3;
  endfunction

  // Fit a wide signed value into w bits; the caller keeps the low w bits
  function automatic logic signed [63:0] fit_val(input logic signed [63:0] v,
                                                 input int unsigned        w);
`ifdef IIR_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
`else
    // Sign-wrap to w bits so the result is correct whatever the caller keeps
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Per-channel coefficient register file: one cfg write port, one read port.
// Configuration macro: none (IIR_SAT_EN affects only the top-level arithmetic).
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CW-1:0]           cfg_ch,
  input  logic [2:0]              cfg_sel,
  input  logic [WIDTH-1:0]        cfg_data,
  input  logic [CW-1:0]           rd_ch,
  output logic signed [WIDTH-1:0] a1,
  output logic signed [WIDTH-1:0] a2,
  output logic signed [WIDTH-1:0] b0,
  output logic signed [WIDTH-1:0] b1,
  output logic signed [WIDTH-1:0] b2
);

  logic signed [WIDTH-1:0] a1_mem [NCH];
  logic signed [WIDTH-1:0] a2_mem [NCH];
  logic signed [WIDTH-1:0] b0_mem [NCH];
  logic signed [WIDTH-1:0] b1_mem [NCH];
  logic signed [WIDTH-1:0] b2_mem [NCH];

  logic wr_ok;
  logic rd_ok;

  // Range checks for the write and read channel indices
  always_comb begin
    wr_ok = cfg_we && (32'(cfg_ch) < NCH);
    rd_ok = (32'(rd_ch) < NCH);
  end

  // Coefficient write; unused select codes and out-of-range channels are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        a1_mem[i] <= '0;
        a2_mem[i] <= '0;
        b0_mem[i] <= '0;
        b1_mem[i] <= '0;
        b2_mem[i] <= '0;
      end
    end else if (wr_ok) begin
      case (sel_e'(cfg_sel))
        SEL_A1:  a1_mem[cfg_ch] <= cfg_data;
        SEL_A2:  a2_mem[cfg_ch] <= cfg_data;
        SEL_B0:  b0_mem[cfg_ch] <= cfg_data;
        SEL_B1:  b1_mem[cfg_ch] <= cfg_data;
        SEL_B2:  b2_mem[cfg_ch] <= cfg_data;
        default: ;
      endcase
    end
  end

  // Asynchronous read: a write on this edge is seen only by later reads
  always_comb begin
    a1 = '0;
    a2 = '0;
    b0 = '0;
    b1 = '0;
    b2 = '0;
    if (rd_ok) begin
      a1 = a1_mem[rd_ch];
      a2 = a2_mem[rd_ch];
      b0 = b0_mem[rd_ch];
      b1 = b1_mem[rd_ch];
      b2 = b2_mem[rd_ch];
    end
  end

endmodule

// File: rtl/iir_biquad_mc.sv
// Multi-channel direct-form-II biquad: shared datapath, per-channel state and
// coefficients, two-stage pipeline (input register, compute + state update).
// Configuration macro: IIR_SAT_EN (saturate w and y instead of wrapping).
module iir_biquad_mc
  import iir_pkg::*;
#(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned FRAC  = WIDTH - 2,
  parameter  int unsigned NCH   = 4,
  localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  input  logic [CW-1:0]    ch_in,
  input  logic             clr,
  input  logic [CW-1:0]    clr_ch,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [2:0]       cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  output logic [WIDTH-1:0] dout,
  output logic             vout,
  output logic [CW-1:0]    ch_out
);

  localparam int unsigned ACC = acc_width(WIDTH);

  // Stage-1 registers
  logic signed [WIDTH-1:0] x_r;
  logic [CW-1:0]           ch_r;
  logic                    v_r;

  // Per-channel filter state
  logic signed [WIDTH-1:0] w1_mem [NCH];
  logic signed [WIDTH-1:0] w2_mem [NCH];

  logic signed [WIDTH-1:0] a1, a2, b0, b1, b2;
  logic signed [WIDTH-1:0] w1_rd, w2_rd;
  logic signed [ACC-1:0]   acc_w, acc_y, w_sh, y_sh;
  logic signed [WIDTH-1:0] w_fit, y_fit;

  iir_coef_bank #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .CW    (CW)
  ) u_coef (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .rd_ch    (ch_r),
    .a1       (a1),
    .a2       (a2),
    .b0       (b0),
    .b1       (b1),
    .b2       (b2)
  );

  // Stage 1: capture the sample; out-of-range channels never become valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r  <= '0;
      ch_r <= '0;
      v_r  <= 1'b0;
    end else begin
      x_r  <= din;
      ch_r <= ch_in;
      v_r  <= vin && (32'(ch_in) < NCH);
    end
  end

  // Stage 2 arithmetic: recursive node w, then output y from the fitted w
  always_comb begin
    w1_rd = '0;
    w2_rd = '0;
    if (32'(ch_r) < NCH) begin
      w1_rd = w1_mem[ch_r];
      w2_rd = w2_mem[ch_r];
    end
    acc_w = (ACC'(x_r) <<< FRAC)
          - (ACC'(a1) * ACC'(w1_rd))
          - (ACC'(a2) * ACC'(w2_rd));
    w_sh  = acc_w >>> FRAC;
    w_fit = WIDTH'(fit_val(64'(w_sh), WIDTH));
    acc_y = (ACC'(b0) * ACC'(w_fit))
          + (ACC'(b1) * ACC'(w1_rd))
          + (ACC'(b2) * ACC'(w2_rd));
    y_sh  = acc_y >>> FRAC;
    y_fit = WIDTH'(fit_val(64'(y_sh), WIDTH));
  end

  // Output register: one-cycle vout pulse per accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= '0;
      vout   <= 1'b0;
      ch_out <= '0;
    end else begin
      vout <= v_r;
      if (v_r) begin
        dout   <= y_fit;
        ch_out <= ch_r;
      end
    end
  end

  // State update; clr is applied last so it overrides a same-channel write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        w1_mem[i] <= '0;
        w2_mem[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (v_r && (32'(ch_r) == i)) begin
          w2_mem[i] <= w1_rd;
          w1_mem[i] <= w_fit;
        end
        if (clr && (32'(clr_ch) == i)) begin
          w1_mem[i] <= '0;
          w2_mem[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc (WIDTH=9, FRAC=7, NCH=4).
module tb_iir_biquad_mc;
  import iir_pkg::*;

  logic       clk;
  logic       rst;
  logic [8:0] din;
  logic       vin;
  logic [1:0] ch_in;
  logic       clr;
  logic [1:0] clr_ch;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [2:0] cfg_sel;
  logic [8:0] cfg_data;
  logic [8:0] dout;
  logic       vout;
  logic [1:0] ch_out;

  int n_cmp;
  int n_bad;

  iir_biquad_mc #(
    .WIDTH (9),
    .FRAC  (7),
    .NCH   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .vin      (vin),
    .ch_in    (ch_in),
    .clr      (clr),
    .clr_ch   (clr_ch),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .dout     (dout),
    .vout     (vout),
    .ch_out   (ch_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic vin;
    int   ch;
    int   din;
    int   dout;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input logic [2:0] sel, input int data);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_sel  = sel;
    cfg_data = 9'(data);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic clear_ch(input int ch);
    clr    = 1'b1;
    clr_ch = 2'(ch);
    tick();
    clr    = 1'b0;
  endtask

  task automatic drive(input logic v, input int ch, input int d);
    vin   = v;
    ch_in = 2'(ch);
    din   = 9'(d);
  endtask

  task automatic chk_out(input string name, input int ch, input int d);
    chk({name, ".vout"}, int'(vout), 1);
    chk({name, ".ch"}, int'(ch_out), ch);
    chk({name, ".dout"}, int'($signed(dout)), d);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // Recursion on ch0 (b0=1.0, a1=-0.5), ch1 gain 0.25, ch2 gain 0.5, ch3 all-zero
    tbl[0]  = '{1'b1, 0,   64,  64};
    tbl[1]  = '{1'b1, 1,   64,  16};
    tbl[2]  = '{1'b1, 0,    0,  32};
    tbl[3]  = '{1'b1, 1,    0,   0};
    tbl[4]  = '{1'b1, 0,    0,  16};
    tbl[5]  = '{1'b1, 1,    0,   0};
    tbl[6]  = '{1'b1, 2,  100,  50};
    tbl[7]  = '{1'b1, 2,   -3,  -2};
    tbl[8]  = '{1'b0, 0,   55,   0};
    tbl[9]  = '{1'b1, 3,   77,   0};
    tbl[10] = '{1'b1, 0,    0,   8};
    tbl[11] = '{1'b1, 2, -100, -50};

    rst = 1'b1; drive(1'b0, 0, 0);
    clr = 1'b0; clr_ch = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    #1;
    chk("reset.dout", int'(dout), 0);
    chk("reset.vout", int'(vout), 0);
    chk("reset.ch", int'(ch_out), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Pass-through gain 0.5 on ch0
    cfg(0, SEL_B0, 64);
    drive(1'b1, 0, 100);
    tick();
    drive(1'b0, 0, 0);
    chk("pass.latency", int'(vout), 0);
    tick();
    chk_out("pass", 0, 50);
    tick();
    chk("pass.pulse", int'(vout), 0);

    // Table-driven interleaved stream
    cfg(0, SEL_B0, 128);
    cfg(0, SEL_A1, 9'h1C0);
    cfg(1, SEL_B0, 32);
    cfg(2, SEL_B0, 64);
    clear_ch(0);
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) drive(tbl[i].vin, tbl[i].ch, tbl[i].din);
      else        drive(1'b0, 0, 0);
      tick();
      if (i > 0) begin
        if (tbl[i-1].vin) chk_out($sformatf("vec%0d", i - 1), tbl[i-1].ch, tbl[i-1].dout);
        else              chk($sformatf("vec%0d.vout", i - 1), int'(vout), 0);
      end
    end

    // Coefficient write coinciding with a stage-2 edge uses the old value
    drive(1'b1, 2, 40);
    tick();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = SEL_B0; cfg_data = 9'd128;
    drive(1'b1, 2, 40);
    tick();
    cfg_we = 1'b0;
    drive(1'b0, 0, 0);
    chk_out("cfg_old", 2, 20);
    tick();
    chk_out("cfg_new", 2, 40);

    // Clear on the stage-2 edge of the second sample
    clear_ch(0);
    drive(1'b1, 0, 64);
    tick();
    drive(1'b1, 0, 0);
    tick();
    chk_out("clr.first", 0, 64);
    clr = 1'b1; clr_ch = 2'd0;
    drive(1'b1, 0, 0);
    tick();
    clr = 1'b0;
    drive(1'b0, 0, 0);
    chk_out("clr.same", 0, 32);
    tick();
    chk_out("clr.after", 0, 0);

    // Overflow of y
    cfg(3, SEL_B0, 255);
    drive(1'b1, 3, 255);
    tick();
    drive(1'b0, 0, 0);
    tick();
`ifdef IIR_SAT_EN
    chk_out("ovf", 3, 255);
`else
    chk_out("ovf", 3, -4);
`endif

    // Reset with a sample in flight
    drive(1'b1, 0, 64);
    tick();
    drive(1'b0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst.vout", int'(vout), 0);
    chk("rst.dout", int'(dout), 0);
    tick();
    chk("rst.held", int'(vout), 0);
    rst = 1'b0;
    tick();
    chk("rst.release", int'(vout), 0);
    drive(1'b1, 0, 64);
    tick();
    drive(1'b0, 0, 0);
    tick();
    chk_out("rst.impulse", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
